// File: rtl/instr_pkg.sv
// Shared instruction-format definitions: mnemonic codes, opcode/func map and field positions,
// used by both the program encoder and the control decoder.
package instr_pkg;

    typedef enum logic [3:0] {
        MN_ADD     = 4'd0,
        MN_AND     = 4'd1,
        MN_OR      = 4'd2,
        MN_XOR     = 4'd3,
        MN_SRL     = 4'd4,
        MN_SLL     = 4'd5,
        MN_ADDI    = 4'd6,
        MN_ANDI    = 4'd7,
        MN_ORI     = 4'd8,
        MN_XORI    = 4'd9,
        MN_LW      = 4'd10,
        MN_SW      = 4'd11,
        MN_BEQ     = 4'd12,
        MN_BNE     = 4'd13,
        MN_J       = 4'd14,
        MN_ILLEGAL = 4'd15
    } mnem_e;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_LOGIC = 6'b000001;
    localparam logic [5:0] OP_SHIFT = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001010;
    localparam logic [5:0] OP_XORI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b001111;
    localparam logic [5:0] OP_BNE   = 6'b010000;
    localparam logic [5:0] OP_J     = 6'b010010;

    localparam logic [5:0] FUNC_ADD = 6'b000001;
    localparam logic [5:0] FUNC_AND = 6'b000001;
    localparam logic [5:0] FUNC_OR  = 6'b000010;
    localparam logic [5:0] FUNC_XOR = 6'b000100;
    localparam logic [5:0] FUNC_SRL = 6'b000010;
    localparam logic [5:0] FUNC_SLL = 6'b000011;

    localparam int OP_LSB  = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SA_LSB  = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;

    function automatic logic [31:0] r_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sa, input logic [5:0] func);
        return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
               (32'(rd) << RD_LSB) | (32'(sa) << SA_LSB) | 32'(func);
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [IMM_W-1:0] imm);
        return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [TGT_W-1:0] tgt);
        return (32'(op) << OP_LSB) | 32'(tgt);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational mnemonic+fields -> instruction word packer with legality flag.
// Build option: IMM_RANGE_CHECK_EN rejects immediates that do not fit their field.
import instr_pkg::*;

module instr_pack (
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic [31:0] raw_word;
    logic        known;
    logic        imm_ok;

    always_comb begin
        raw_word = '0;
        known    = 1'b1;
        case (mnem_e'(mnem))
            MN_ADD:  raw_word = r_word(OP_ADD,   rs, rt, rd, 5'd0, FUNC_ADD);
            MN_AND:  raw_word = r_word(OP_LOGIC, rs, rt, rd, 5'd0, FUNC_AND);
            MN_OR:   raw_word = r_word(OP_LOGIC, rs, rt, rd, 5'd0, FUNC_OR);
            MN_XOR:  raw_word = r_word(OP_LOGIC, rs, rt, rd, 5'd0, FUNC_XOR);
            // Shifts take their amount from sa; rs has no meaning and stays zero.
            MN_SRL:  raw_word = r_word(OP_SHIFT, 5'd0, rt, rd, sa, FUNC_SRL);
            MN_SLL:  raw_word = r_word(OP_SHIFT, 5'd0, rt, rd, sa, FUNC_SLL);
            MN_ADDI: raw_word = i_word(OP_ADDI, rs, rt, imm[15:0]);
            MN_ANDI: raw_word = i_word(OP_ANDI, rs, rt, imm[15:0]);
            MN_ORI:  raw_word = i_word(OP_ORI,  rs, rt, imm[15:0]);
            MN_XORI: raw_word = i_word(OP_XORI, rs, rt, imm[15:0]);
            MN_LW:   raw_word = i_word(OP_LW,   rs, rt, imm[15:0]);
            MN_SW:   raw_word = i_word(OP_SW,   rs, rt, imm[15:0]);
            MN_BEQ:  raw_word = i_word(OP_BEQ,  rs, rt, imm[15:0]);
            MN_BNE:  raw_word = i_word(OP_BNE,  rs, rt, imm[15:0]);
            MN_J:    raw_word = j_word(OP_J, imm[25:0]);
            default: known    = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        imm_ok = 1'b1;
        case (mnem_e'(mnem))
            // Sign-extended fields: bits 31..15 must all equal the sign bit.
            MN_ADDI, MN_LW, MN_SW, MN_BEQ, MN_BNE:
                imm_ok = (imm[31:15] == 17'h00000) || (imm[31:15] == 17'h1FFFF);
            MN_ANDI, MN_ORI, MN_XORI:
                imm_ok = (imm[31:16] == 16'h0000);
            MN_J:
                imm_ok = (imm[31:26] == 6'd0);
            default:
                imm_ok = 1'b1;
        endcase
    end
`else
    logic unused_imm_hi;
    assign imm_ok        = 1'b1;
    assign unused_imm_hi = ^imm[31:26];
`endif

    assign legal = known & imm_ok;
    assign word  = legal ? raw_word : 32'd0;

endmodule

// File: rtl/instr_encoder.sv
// Session-based program loader: accepts records over valid/ready, encodes them and writes
// consecutive instruction-memory words through a held-until-ack write register.
import instr_pkg::*;

module instr_encoder #(
    parameter int AW    = 10,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_mnem,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_sa,
    input  logic [31:0]      in_imm,
    output logic             im_we,
    output logic [AW-1:0]    im_addr,
    output logic [31:0]      im_wdata,
    input  logic             im_ack,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e           state_reg, state_next;
    logic [AW-1:0]    ptr_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic             im_we_reg;
    logic [AW-1:0]    im_addr_reg;
    logic [31:0]      im_wdata_reg;
    logic             err_reg;

    logic [31:0]      packed_word;
    logic             packed_legal;
    logic             accept;

    instr_pack u_pack (
        .mnem  (in_mnem),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .sa    (in_sa),
        .imm   (in_imm),
        .word  (packed_word),
        .legal (packed_legal)
    );

    // A new record may enter only when the write register is free or being freed this cycle.
    assign in_ready = (state_reg == ST_RUN) && (remaining_reg != '0) && (!im_we_reg || im_ack);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            im_we_reg     <= 1'b0;
            im_addr_reg   <= '0;
            im_wdata_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                ptr_reg       <= base_addr;
                remaining_reg <= count;
                err_reg       <= 1'b0;
            end
            if (accept) begin
                remaining_reg <= remaining_reg - 1'b1;
                if (packed_legal) begin
                    ptr_reg      <= ptr_reg + 1'b1;
                    im_addr_reg  <= ptr_reg;
                    im_wdata_reg <= packed_word;
                end else begin
                    err_reg <= 1'b1;
                end
            end
            if (accept && packed_legal)
                im_we_reg <= 1'b1;
            else if (im_ack)
                im_we_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (remaining_reg == '0 && !im_we_reg) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ST_RUN);
        done = (state_reg == ST_DONE);
    end

    assign im_we    = im_we_reg;
    assign im_addr  = im_addr_reg;
    assign im_wdata = im_wdata_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; honours IMM_RANGE_CHECK_EN when defined.
module tb_instr_encoder;

    localparam int AW    = 10;
    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [CNT_W-1:0] count = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_mnem = '0;
    logic [4:0]       in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
    logic [31:0]      in_imm = '0;
    logic             im_we;
    logic [AW-1:0]    im_addr;
    logic [31:0]      im_wdata;
    logic             im_ack = 1'b0;
    logic             busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            done_cnt = 0;
    int            busy_cnt = 0;

    instr_encoder #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa), .in_imm(in_imm), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .im_ack(im_ack), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Log completed writes and status pulses mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (im_we && im_ack) begin
            wa_q.push_back(im_addr);
            wd_q.push_back(im_wdata);
            $display("write addr=0x%03h data=0x%08h", im_addr, im_wdata);
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CNT_W-1:0] c);
        start = 1'b1; base_addr = b; count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rec(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sa, input logic [31:0] imm);
        int n = 0;
        in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa; in_imm = imm;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout mnem=%0d in_ready=%0b required 1", m, in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout done_cnt=%0d required 1", done_cnt);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({in_ready, im_we, busy, done, err} !== 5'b0 || im_addr !== '0 || im_wdata !== '0) begin
            errors++;
            $display("FAIL reset_state rdy/we/busy/done/err=%b addr=%h data=%h required all 0",
                     {in_ready, im_we, busy, done, err}, im_addr, im_wdata);
        end
        rst_n = 1'b1;
        tick();
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        logic [AW-1:0] ea[3];
        logic [31:0]   ed[3];
        ea = '{10'h010, 10'h011, 10'h012};
        ed = '{32'h00221801, 32'h1424FFFF, 32'h48000040};
        clear_log();
        im_ack = 1'b1;
        do_start(10'h010, 11'd3);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy busy=%b required 1", busy);
        end
        send_rec(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        send_rec(4'd6, 5'd1, 5'd4, 5'd0, 5'd0, 32'hFFFFFFFF);
        send_rec(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 32'h40);
        wait_done();
        checks++;
        if (wa_q.size() != 3) begin
            errors++; $display("FAIL basic_count writes=%0d required 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL basic_write%0d addr=%h data=%h required addr=%h data=%h",
                             i, wa_q[i], wd_q[i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (err !== 1'b0 || done_cnt != 1) begin
            errors++; $display("FAIL basic_status err=%b done_cycles=%0d required err=0 done_cycles=1",
                               err, done_cnt);
        end
    endtask

    task automatic test_formats();
        logic [3:0]  m[6];
        logic [4:0]  rs[6], rt[6], rd[6], sa[6];
        logic [31:0] im[6], ed[6];
        m  = '{4'd1, 4'd3, 4'd4, 4'd7, 4'd10, 4'd13};
        rs = '{5'd1, 5'd4, 5'd0, 5'd1, 5'd3, 5'd6};
        rt = '{5'd2, 5'd5, 5'd7, 5'd1, 5'd4, 5'd7};
        rd = '{5'd3, 5'd6, 5'd8, 5'd0, 5'd0, 5'd0};
        sa = '{5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0};
        im = '{32'd0, 32'd0, 32'd0, 32'h0000F0F0, 32'h10, 32'h7FFF};
        ed = '{32'h04221801, 32'h04853004, 32'h080747C2, 32'h2421F0F0, 32'h34640010, 32'h40C77FFF};
        clear_log();
        im_ack = 1'b1;
        do_start(10'h100, 11'd6);
        for (int i = 0; i < 6; i++) send_rec(m[i], rs[i], rt[i], rd[i], sa[i], im[i]);
        wait_done();
        checks++;
        if (wa_q.size() != 6) begin
            errors++; $display("FAIL formats_count writes=%0d required 6", wa_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wa_q[i] !== 10'(10'h100 + i) || wd_q[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL formats_write%0d addr=%h data=%h required addr=%h data=%h",
                             i, wa_q[i], wd_q[i], 10'(10'h100 + i), ed[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        im_ack = 1'b0;
        do_start(10'h020, 11'd2);
        send_rec(4'd2, 5'd5, 5'd6, 5'd7, 5'd0, 32'd0);
        in_valid = 1'b1; in_mnem = 4'd5; in_rs = 5'd0; in_rt = 5'd8; in_rd = 5'd9; in_sa = 5'd4;
        in_imm = 32'd0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (im_we !== 1'b1 || im_addr !== 10'h020 || im_wdata !== 32'h04A63802 ||
                in_ready !== 1'b0 || wa_q.size() != 0) begin
                errors++;
                $display("FAIL stall_cycle%0d we=%b addr=%h data=%h rdy=%b writes=%0d required we=1 addr=020 data=04a63802 rdy=0 writes=0",
                         i, im_we, im_addr, im_wdata, in_ready, wa_q.size());
            end
            tick();
        end
        im_ack = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        wait_done();
        checks++;
        if (wa_q.size() != 2) begin
            errors++; $display("FAIL stall_count writes=%0d required 2", wa_q.size());
        end else begin
            checks++;
            if (wa_q[1] !== 10'h021 || wd_q[1] !== 32'h08084903) begin
                errors++;
                $display("FAIL stall_second addr=%h data=%h required addr=021 data=08084903",
                         wa_q[1], wd_q[1]);
            end
        end
    endtask

    task automatic test_illegal();
        clear_log();
        im_ack = 1'b1;
        do_start(10'h030, 11'd2);
        send_rec(4'd15, 5'd1, 5'd2, 5'd3, 5'd4, 32'h5);
        send_rec(4'd9, 5'd2, 5'd3, 5'd0, 5'd0, 32'h00AB);
        wait_done();
        checks++;
        if (wa_q.size() != 1 || done_cnt != 1) begin
            errors++; $display("FAIL illegal_count writes=%0d done_cycles=%0d required 1 and 1",
                               wa_q.size(), done_cnt);
        end else begin
            checks++;
            if (wa_q[0] !== 10'h030 || wd_q[0] !== 32'h304300AB) begin
                errors++;
                $display("FAIL illegal_write addr=%h data=%h required addr=030 data=304300ab",
                         wa_q[0], wd_q[0]);
            end
        end
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL illegal_err err=%b required 1", err);
        end
    endtask

    task automatic test_zero_count();
        clear_log();
        do_start(10'h055, 11'd0);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL zero_err_clear err=%b required 0", err);
        end
        wait_done();
        checks++;
        if (busy_cnt != 1 || done_cnt != 1 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL zero_count busy_cycles=%0d done_cycles=%0d writes=%0d required 1 1 0",
                     busy_cnt, done_cnt, wa_q.size());
        end
    endtask

    task automatic test_wrap();
        clear_log();
        im_ack = 1'b1;
        do_start(10'h3FF, 11'd2);
        send_rec(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFC);
        send_rec(4'd11, 5'd29, 5'd31, 5'd0, 5'd0, 32'd8);
        wait_done();
        checks++;
        if (wa_q.size() != 2) begin
            errors++; $display("FAIL wrap_count writes=%0d required 2", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 10'h3FF || wd_q[0] !== 32'h3C22FFFC ||
                wa_q[1] !== 10'h000 || wd_q[1] !== 32'h3BBF0008) begin
                errors++;
                $display("FAIL wrap_writes %h=%h %h=%h required 3ff=3c22fffc 000=3bbf0008",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            end
        end
    endtask

    task automatic test_range_and_reset();
        int            exp_writes;
        logic          exp_err;
        logic [AW-1:0] exp_addr;
`ifdef IMM_RANGE_CHECK_EN
        exp_writes = 0; exp_err = 1'b1; exp_addr = 10'h040;
`else
        exp_writes = 1; exp_err = 1'b0; exp_addr = 10'h041;
`endif
        clear_log();
        im_ack = 1'b1;
        do_start(10'h040, 11'd2);
        send_rec(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00010000);
        tick();
        im_ack = 1'b0;
        checks++;
        if (wa_q.size() != exp_writes || err !== exp_err) begin
            errors++; $display("FAIL range_ori writes=%0d err=%b required writes=%0d err=%b",
                               wa_q.size(), err, exp_writes, exp_err);
        end else if (exp_writes == 1) begin
            checks++;
            if (wd_q[0] !== 32'h28220000) begin
                errors++; $display("FAIL range_trunc data=%h required 28220000", wd_q[0]);
            end
        end
        send_rec(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 32'h1234);
        checks++;
        if (im_we !== 1'b1 || im_addr !== exp_addr || im_wdata !== 32'h28221234) begin
            errors++; $display("FAIL pending_write we=%b addr=%h data=%h required we=1 addr=%h data=28221234",
                               im_we, im_addr, im_wdata, exp_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (im_we !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || im_addr !== '0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL async_reset we=%b busy=%b err=%b addr=%h rdy=%b required all 0",
                               im_we, busy, err, im_addr, in_ready);
        end
        tick(); tick();
        rst_n = 1'b1;
        im_ack = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (im_we !== 1'b0 || wa_q.size() != exp_writes || done_cnt != 0) begin
            errors++; $display("FAIL post_reset we=%b writes=%0d done_cycles=%0d required we=0 writes=%0d done=0",
                               im_we, wa_q.size(), done_cnt, exp_writes);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_formats();
        test_backpressure();
        test_illegal();
        test_zero_count();
        test_wrap();
        test_range_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
